noc_packetizer: RTL and testbench

Local-side network interface that turns a transfer request plus a stream of payload words into a framed NoC packet. The packet is a header flit followed by payload flits, with `is_header`/`is_tail` markings. It drives one router local input port through the `receive_*` side of `Noc_connector`, taking the place of a test node's sender half. It is the stage directly upstream of the fabric's local port.

---
 rtl/noc_packetizer.sv | 128 ++++++++++++
 tb/tb_noc_packetizer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/noc_packetizer.sv
// NoC packetizer: frames a transfer request plus payload words into a header flit followed by payload flits.
// The output toward the router is a single register stage with valid/ready handshaking.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_packetizer #(
    parameter int X_ID       = 0,
    parameter int Y_ID       = 0,
    parameter int DATA_WIDTH = `Noc_Data_Width
) (
    input  logic                  noc_clk,
    input  logic                  noc_rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_dest_x,
    input  logic [3:0]            req_dest_y,
    input  logic [7:0]            req_len,
    input  logic                  data_valid,
    output logic                  data_ready,
    input  logic [DATA_WIDTH-1:0] data_word,
    output logic                  sender_valid,
    input  logic                  sender_ready,
    output logic [DATA_WIDTH-1:0] sender_flit,
    output logic                  sender_is_header,
    output logic                  sender_is_tail,
    output logic [15:0]           pkt_sent_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_BODY, S_DRAIN} state_t;

    state_t                state_q, state_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] flit_q, flit_d;
    logic                  hdr_q, hdr_d;
    logic                  tail_q, tail_d;
    logic [7:0]            rem_q, rem_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] header;
    logic                  reg_free;

    always_comb begin
        header       = '0;
        header[23:0] = {req_len, 4'(Y_ID), 4'(X_ID), req_dest_y, req_dest_x};
    end

    assign reg_free = !valid_q || sender_ready;

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        flit_d     = flit_q;
        hdr_d      = hdr_q;
        tail_d     = tail_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        req_ready  = 1'b0;
        data_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    valid_d = 1'b1;
                    flit_d  = header;
                    hdr_d   = 1'b1;
                    tail_d  = (req_len == 8'd0);
                    rem_d   = req_len;
                    state_d = (req_len == 8'd0) ? S_DRAIN : S_BODY;
                end
            end
            S_BODY: begin
                if (reg_free) begin
                    if (data_valid) begin
                        data_ready = 1'b1;
                        valid_d    = 1'b1;
                        flit_d     = data_word;
                        hdr_d      = 1'b0;
                        tail_d     = (rem_q == 8'd1);
                        rem_d      = rem_q - 8'd1;
                        if (rem_q == 8'd1) state_d = S_DRAIN;
                    end else begin
                        // Previous flit left and nothing to replace it: emit a bubble.
                        valid_d = 1'b0;
                    end
                end
            end
            S_DRAIN: begin
                if (valid_q && sender_ready) begin
                    valid_d = 1'b0;
                    cnt_d   = cnt_q + 16'd1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (!noc_rst_n) begin
            req_ready  = 1'b0;
            data_ready = 1'b0;
        end
    end

    always_ff @(posedge noc_clk) begin
        if (!noc_rst_n) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            flit_q  <= '0;
            hdr_q   <= 1'b0;
            tail_q  <= 1'b0;
            rem_q   <= 8'd0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            flit_q  <= flit_d;
            hdr_q   <= hdr_d;
            tail_q  <= tail_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sender_valid     = valid_q;
    assign sender_flit      = flit_q;
    assign sender_is_header = hdr_q;
    assign sender_is_tail   = tail_q;
    assign pkt_sent_cnt     = cnt_q;

endmodule

// File: tb/tb_noc_packetizer.sv
// Directed bench for noc_packetizer: expected flits are queued when a request is
// driven and popped on each sender handshake.
module tb_noc_packetizer;
    localparam int DW = 32;

    logic          noc_clk = 1'b0;
    logic          noc_rst_n;
    logic          req_valid, req_ready;
    logic [3:0]    req_dest_x, req_dest_y;
    logic [7:0]    req_len;
    logic          data_valid, data_ready;
    logic [DW-1:0] data_word;
    logic          sender_valid, sender_ready;
    logic [DW-1:0] sender_flit;
    logic          sender_is_header, sender_is_tail;
    logic [15:0]   pkt_sent_cnt;

    always #5 noc_clk = ~noc_clk;

    noc_packetizer #(.X_ID(0), .Y_ID(0), .DATA_WIDTH(DW)) dut (
        .noc_clk(noc_clk), .noc_rst_n(noc_rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dest_x(req_dest_x), .req_dest_y(req_dest_y), .req_len(req_len),
        .data_valid(data_valid), .data_ready(data_ready), .data_word(data_word),
        .sender_valid(sender_valid), .sender_ready(sender_ready), .sender_flit(sender_flit),
        .sender_is_header(sender_is_header), .sender_is_tail(sender_is_tail),
        .pkt_sent_cnt(pkt_sent_cnt)
    );

    int total = 0, passed = 0, failed = 0;
    logic [33:0]   exp_q[$];
    logic [DW-1:0] src_q[$];
    int  cyc_n = 0, hdr_cyc = 0, tail_cyc = -100, last_gap = -1, last_span = -1;
    int  rr_cnt = 0, acc_cnt = 0;
    bit  data_en = 1'b0, saw_dready = 1'b0, prev_stall = 1'b0;
    logic [35:0] prev_obs = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_data();
        data_valid = data_en && (src_q.size() > 0);
        data_word  = (src_q.size() > 0) ? src_q[0] : '0;
    endtask

    task automatic push_pkt(input logic [3:0] dx, input logic [3:0] dy, input logic [7:0] len,
                            input logic [DW-1:0] base);
        exp_q.push_back({1'b1, (len == 8'd0), 8'h00, len, 4'h0, 4'h0, dy, dx});
        for (int i = 0; i < int'(len); i++) begin
            exp_q.push_back({1'b0, (i == int'(len) - 1), base + DW'(i)});
            src_q.push_back(base + DW'(i));
        end
    endtask

    task automatic set_req(input logic v, input logic [3:0] dx, input logic [3:0] dy,
                           input logic [7:0] len);
        req_valid = v; req_dest_x = dx; req_dest_y = dy; req_len = len;
    endtask

    // Sample at the falling edge, then advance one rising edge.
    task automatic monitor();
        logic [35:0] obs;
        obs = {sender_valid, sender_is_header, sender_is_tail, 1'b0, sender_flit};
        if (prev_stall) chk("stall_hold", 64'(obs), 64'(prev_obs));
        if (sender_valid && !sender_ready) chk("stall_data_ready", 64'(data_ready), 64'(0));
        if (data_ready) saw_dready = 1'b1;
        if (req_ready) rr_cnt++;
        if (sender_valid && sender_ready) begin
            if (exp_q.size() == 0) chk("scoreboard_nonempty", 64'(exp_q.size()), 64'(1));
            else chk("flit", 64'({sender_is_header, sender_is_tail, sender_flit}),
                     64'(exp_q.pop_front()));
            if (sender_is_header) begin last_gap = cyc_n - tail_cyc; hdr_cyc = cyc_n; end
            if (sender_is_tail) begin last_span = cyc_n - hdr_cyc; tail_cyc = cyc_n; end
        end
        prev_stall = sender_valid && !sender_ready;
        prev_obs   = obs;
    endtask

    task automatic cyc();
        bit dhs, rhs;
        @(negedge noc_clk);
        monitor();
        dhs = data_valid && data_ready;
        rhs = req_valid && req_ready;
        @(posedge noc_clk);
        #1;
        cyc_n++;
        if (dhs) void'(src_q.pop_front());
        if (rhs) acc_cnt++;
        drive_data();
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin cyc(); n++; end
        chk("drain_timeout", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        noc_rst_n = 1'b0; sender_ready = 1'b1; data_en = 1'b1;
        set_req(1'b0, 4'h0, 4'h0, 8'h00);
        drive_data();
        repeat (2) cyc();
        chk("rst_valid", 64'(sender_valid), 64'(0));
        chk("rst_flit", 64'({sender_is_header, sender_is_tail, sender_flit}), 64'(0));
        chk("rst_cnt", 64'(pkt_sent_cnt), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_data_ready", 64'(data_ready), 64'(0));
        noc_rst_n = 1'b1;
        #1 chk("idle_req_ready", 64'(req_ready), 64'(1));

        // Single 3-flit packet, streaming.
        push_pkt(4'd1, 4'd1, 8'd3, 32'hA0);
        drive_data();
        set_req(1'b1, 4'd1, 4'd1, 8'd3);
        cyc();
        set_req(1'b0, 4'd9, 4'd9, 8'd9);
        chk("hdr_latency", 64'({sender_valid, sender_is_header, sender_flit}),
            64'({1'b1, 1'b1, 32'h00030011}));
        chk("req_ready_body", 64'(req_ready), 64'(0));
        wait_done(20);
        chk("span_len3", 64'(last_span), 64'(3));
        chk("cnt_1", 64'(pkt_sent_cnt), 64'(1));

        // Zero-length packet with a stray data word offered.
        saw_dready = 1'b0;
        src_q.push_back(32'hDEAD);
        push_pkt(4'd1, 4'd0, 8'd0, 32'h0);
        drive_data();
        set_req(1'b1, 4'd1, 4'd0, 8'd0);
        cyc();
        set_req(1'b0, 4'd0, 4'd0, 8'd0);
        wait_done(10);
        chk("zl_no_data_ready", 64'(saw_dready), 64'(0));
        src_q.delete();
        drive_data();
        chk("cnt_2", 64'(pkt_sent_cnt), 64'(2));

        // Backpressure with ready pattern 1,0,0,1.
        push_pkt(4'd2, 4'd2, 8'd4, 32'hB0);
        drive_data();
        set_req(1'b1, 4'd2, 4'd2, 8'd4);
        cyc();
        set_req(1'b0, 4'd0, 4'd0, 8'd0);
        for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
            sender_ready = ((k % 4) == 0) || ((k % 4) == 3);
            cyc();
        end
        sender_ready = 1'b1;
        chk("bp_drained", 64'(exp_q.size()), 64'(0));
        chk("cnt_3", 64'(pkt_sent_cnt), 64'(3));

        // Data starvation for 3 cycles after the first payload word.
        push_pkt(4'd3, 4'd1, 8'd4, 32'hC0);
        drive_data();
        set_req(1'b1, 4'd3, 4'd1, 8'd4);
        cyc();
        set_req(1'b0, 4'd0, 4'd0, 8'd0);
        cyc();
        data_en = 1'b0;
        drive_data();
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("starve_bubble", 64'(sender_valid), 64'(0));
        end
        data_en = 1'b1;
        drive_data();
        wait_done(20);
        chk("cnt_4", 64'(pkt_sent_cnt), 64'(4));

        // Back-to-back requests, req_valid held high.
        push_pkt(4'd2, 4'd3, 8'd2, 32'hE0);
        push_pkt(4'd2, 4'd3, 8'd2, 32'hE2);
        drive_data();
        acc_cnt = 0; rr_cnt = 0;
        set_req(1'b1, 4'd2, 4'd3, 8'd2);
        for (int n = 0; n < 30 && acc_cnt < 2; n++) cyc();
        set_req(1'b0, 4'd0, 4'd0, 8'd0);
        chk("b2b_accepts", 64'(acc_cnt), 64'(2));
        wait_done(20);
        chk("b2b_gap", 64'(last_gap), 64'(2));
        chk("b2b_span", 64'(last_span), 64'(2));
        chk("b2b_req_ready_cycles", 64'(rr_cnt), 64'(2));
        chk("cnt_6", 64'(pkt_sent_cnt), 64'(6));

        // Reset after one of five payload flits.
        push_pkt(4'd1, 4'd2, 8'd5, 32'hD0);
        drive_data();
        set_req(1'b1, 4'd1, 4'd2, 8'd5);
        cyc();
        set_req(1'b0, 4'd0, 4'd0, 8'd0);
        cyc();
        cyc();
        noc_rst_n = 1'b0;
        cyc();
        chk("rst_mid_valid", 64'(sender_valid), 64'(0));
        chk("rst_mid_cnt", 64'(pkt_sent_cnt), 64'(0));
        chk("rst_mid_req_ready", 64'(req_ready), 64'(0));
        exp_q.delete();
        src_q.delete();
        drive_data();
        noc_rst_n = 1'b1;
        #1 chk("rst_rel_req_ready", 64'(req_ready), 64'(1));
        cyc();
        chk("rst_rel_idle_valid", 64'(sender_valid), 64'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
